// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that time-shares one external 4-bit adder stage,
// feeding it one operand nibble per cycle, LSB first, with a rippling carry.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;

  // Sequencer: add_a/add_b/add_cin are registered one nibble ahead, so the
  // operand registers hold only the nibbles not yet presented and add_cin
  // doubles as the running carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      add_a     <= 4'd0;
      add_b     <= 4'd0;
      add_cin   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r   <= RUN;
            busy      <= 1'b1;
            idx_r     <= '0;
            a_r       <= op_a >> 3'd4;
            b_r       <= op_b >> 3'd4;
            add_a     <= op_a[3:0];
            add_b     <= op_b[3:0];
            add_cin   <= carry_in;
            result    <= '0;
            carry_out <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          result[{idx_r, 2'b00} +: 4] <= add_sum;
          if (idx_r == LAST_IDX) begin
            state_r   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            carry_out <= add_cout;
            idx_r     <= '0;
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            add_cin   <= 1'b0;
          end else begin
            idx_r   <= idx_r + IW'(1);
            a_r     <= a_r >> 3'd4;
            b_r     <= b_r >> 3'd4;
            add_a   <= a_r[3:0];
            add_b   <= b_r[3:0];
            add_cin <= add_cout;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          add_a   <= 4'd0;
          add_b   <= 4'd0;
          add_cin <= 1'b0;
        end
      endcase
    end
  end

endmodule
